// File: rtl/sap_control_unit_if.sv
// Control-unit <-> SAP-1 datapath bundle: the opcode and flags go into the sequencer,
// and the microstep plus every bus-enable/load strobe come out of it.
interface sap_control_unit_if #(
    parameter int OP_WIDTH   = 4,
    parameter int STEP_WIDTH = 3
);
    logic [OP_WIDTH-1:0]   opcode;
    logic                  carry;
    logic                  zero;
    logic [STEP_WIDTH-1:0] t_state;
    logic                  hlt;
    logic                  mi;
    logic                  ri;
    logic                  ro;
    logic                  ii;
    logic                  io;
    logic                  ai;
    logic                  ao;
    logic                  eo;
    logic                  su;
    logic                  bi;
    logic                  oi;
    logic                  ce;
    logic                  co;
    logic                  j;
    logic                  fi;

    modport master (
        input  opcode, carry, zero,
        output t_state, hlt, mi, ri, ro, ii, io, ai, ao, eo, su, bi, oi, ce, co, j, fi
    );

    modport slave (
        output opcode, carry, zero,
        input  t_state, hlt, mi, ri, ro, ii, io, ai, ao, eo, su, bi, oi, ce, co, j, fi
    );
endinterface

// File: rtl/sap_control_unit.sv
// SAP-1 microcoded sequencer: a fixed T-state ring per instruction plus a RUN/HALTED mode.
// The control word is a pure decode of the registered step/mode, the opcode and the flags.
module sap_control_unit #(
    parameter int OP_WIDTH   = 4,
    parameter int NUM_STEPS  = 5,
    parameter int STEP_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    sap_control_unit_if.master    bus
);
    localparam logic [0:0] MODE_RUN    = 1'b0;
    localparam logic [0:0] MODE_HALTED = 1'b1;

    localparam logic [OP_WIDTH-1:0] OP_LDA = OP_WIDTH'(4'b0001);
    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(4'b0010);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(4'b0011);
    localparam logic [OP_WIDTH-1:0] OP_STA = OP_WIDTH'(4'b0100);
    localparam logic [OP_WIDTH-1:0] OP_LDI = OP_WIDTH'(4'b0101);
    localparam logic [OP_WIDTH-1:0] OP_JMP = OP_WIDTH'(4'b0110);
    localparam logic [OP_WIDTH-1:0] OP_JC  = OP_WIDTH'(4'b0111);
    localparam logic [OP_WIDTH-1:0] OP_JZ  = OP_WIDTH'(4'b1000);
    localparam logic [OP_WIDTH-1:0] OP_OUT = OP_WIDTH'(4'b1110);
    localparam logic [OP_WIDTH-1:0] OP_HLT = OP_WIDTH'(4'b1111);

    localparam logic [STEP_WIDTH-1:0] STEP_T0   = STEP_WIDTH'(0);
    localparam logic [STEP_WIDTH-1:0] STEP_T1   = STEP_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] STEP_T2   = STEP_WIDTH'(2);
    localparam logic [STEP_WIDTH-1:0] STEP_T3   = STEP_WIDTH'(3);
    localparam logic [STEP_WIDTH-1:0] STEP_T4   = STEP_WIDTH'(4);
    localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(NUM_STEPS - 1);

    localparam int B_HLT = 15;
    localparam int B_MI  = 14;
    localparam int B_RI  = 13;
    localparam int B_RO  = 12;
    localparam int B_II  = 11;
    localparam int B_IO  = 10;
    localparam int B_AI  = 9;
    localparam int B_AO  = 8;
    localparam int B_EO  = 7;
    localparam int B_SU  = 6;
    localparam int B_BI  = 5;
    localparam int B_OI  = 4;
    localparam int B_CE  = 3;
    localparam int B_CO  = 2;
    localparam int B_J   = 1;
    localparam int B_FI  = 0;

    logic [STEP_WIDTH-1:0] step_r;
    logic [0:0]            mode_r;
    logic [15:0]           ctrl_s;

    // Step ring and run/halt mode; HLT freezes the ring at T2 until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_r <= {STEP_WIDTH{1'b0}};
            mode_r <= MODE_RUN;
        end else begin
            case (mode_r)
                MODE_RUN: begin
                    if ((step_r == STEP_T2) && (bus.opcode == OP_HLT)) begin
                        mode_r <= MODE_HALTED;
                    end else if (step_r == STEP_LAST) begin
                        step_r <= {STEP_WIDTH{1'b0}};
                    end else begin
                        step_r <= step_r + STEP_WIDTH'(1);
                    end
                end
                MODE_HALTED: begin
                    mode_r <= MODE_HALTED;
                end
                default: begin
                    step_r <= {STEP_WIDTH{1'b0}};
                    mode_r <= MODE_RUN;
                end
            endcase
        end
    end

    // Microcode decode; reset forces a quiet word so an aborted instruction emits nothing.
    always_comb begin
        ctrl_s = 16'h0000;
        if (rst) begin
            ctrl_s = 16'h0000;
        end else if (mode_r == MODE_HALTED) begin
            ctrl_s[B_HLT] = 1'b1;
        end else begin
            case (step_r)
                STEP_T0: begin
                    ctrl_s[B_CO] = 1'b1;
                    ctrl_s[B_MI] = 1'b1;
                end
                STEP_T1: begin
                    ctrl_s[B_RO] = 1'b1;
                    ctrl_s[B_II] = 1'b1;
                    ctrl_s[B_CE] = 1'b1;
                end
                STEP_T2: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl_s[B_IO] = 1'b1;
                            ctrl_s[B_MI] = 1'b1;
                        end
                        OP_LDI: begin
                            ctrl_s[B_IO] = 1'b1;
                            ctrl_s[B_AI] = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl_s[B_IO] = 1'b1;
                            ctrl_s[B_J]  = 1'b1;
                        end
                        OP_JC: begin
                            ctrl_s[B_IO] = 1'b1;
                            ctrl_s[B_J]  = bus.carry;
                        end
                        OP_JZ: begin
                            ctrl_s[B_IO] = 1'b1;
                            ctrl_s[B_J]  = bus.zero;
                        end
                        OP_OUT: begin
                            ctrl_s[B_AO] = 1'b1;
                            ctrl_s[B_OI] = 1'b1;
                        end
                        OP_HLT: begin
                            ctrl_s[B_HLT] = 1'b1;
                        end
                        default: begin
                            ctrl_s = 16'h0000;
                        end
                    endcase
                end
                STEP_T3: begin
                    case (bus.opcode)
                        OP_LDA: begin
                            ctrl_s[B_RO] = 1'b1;
                            ctrl_s[B_AI] = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl_s[B_RO] = 1'b1;
                            ctrl_s[B_BI] = 1'b1;
                        end
                        OP_STA: begin
                            ctrl_s[B_AO] = 1'b1;
                            ctrl_s[B_RI] = 1'b1;
                        end
                        default: begin
                            ctrl_s = 16'h0000;
                        end
                    endcase
                end
                STEP_T4: begin
                    case (bus.opcode)
                        OP_ADD, OP_SUB: begin
                            ctrl_s[B_EO] = 1'b1;
                            ctrl_s[B_AI] = 1'b1;
                            ctrl_s[B_FI] = 1'b1;
                            ctrl_s[B_SU] = (bus.opcode == OP_SUB);
                        end
                        default: begin
                            ctrl_s = 16'h0000;
                        end
                    endcase
                end
                default: begin
                    ctrl_s = 16'h0000;
                end
            endcase
        end
    end

    assign bus.t_state = step_r;
    assign bus.hlt     = ctrl_s[B_HLT];
    assign bus.mi      = ctrl_s[B_MI];
    assign bus.ri      = ctrl_s[B_RI];
    assign bus.ro      = ctrl_s[B_RO];
    assign bus.ii      = ctrl_s[B_II];
    assign bus.io      = ctrl_s[B_IO];
    assign bus.ai      = ctrl_s[B_AI];
    assign bus.ao      = ctrl_s[B_AO];
    assign bus.eo      = ctrl_s[B_EO];
    assign bus.su      = ctrl_s[B_SU];
    assign bus.bi      = ctrl_s[B_BI];
    assign bus.oi      = ctrl_s[B_OI];
    assign bus.ce      = ctrl_s[B_CE];
    assign bus.co      = ctrl_s[B_CO];
    assign bus.j       = ctrl_s[B_J];
    assign bus.fi      = ctrl_s[B_FI];
endmodule

// File: tb/tb_sap_control_unit.sv
// Self-checking bench for sap_control_unit: directed instruction walks followed by a
// randomized stream, every cycle compared against a table-driven microcode model.
module tb_sap_control_unit;
    localparam int NUM_STEPS = 5;

    // Control-word packing used by the bench only
    localparam logic [15:0] W_HLT = 16'h8000;
    localparam logic [15:0] W_MI  = 16'h4000;
    localparam logic [15:0] W_RI  = 16'h2000;
    localparam logic [15:0] W_RO  = 16'h1000;
    localparam logic [15:0] W_II  = 16'h0800;
    localparam logic [15:0] W_IO  = 16'h0400;
    localparam logic [15:0] W_AI  = 16'h0200;
    localparam logic [15:0] W_AO  = 16'h0100;
    localparam logic [15:0] W_EO  = 16'h0080;
    localparam logic [15:0] W_SU  = 16'h0040;
    localparam logic [15:0] W_BI  = 16'h0020;
    localparam logic [15:0] W_OI  = 16'h0010;
    localparam logic [15:0] W_CE  = 16'h0008;
    localparam logic [15:0] W_CO  = 16'h0004;
    localparam logic [15:0] W_J   = 16'h0002;
    localparam logic [15:0] W_FI  = 16'h0001;

    logic clk = 1'b0;
    logic rst;

    sap_control_unit_if #(.OP_WIDTH(4), .STEP_WIDTH(3)) bus ();

    sap_control_unit #(.OP_WIDTH(4), .NUM_STEPS(NUM_STEPS), .STEP_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int m_step   = 0;
    bit m_halted = 1'b0;
    logic [15:0] ucode [16][8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic build_ucode();
        for (int op = 0; op < 16; op++) begin
            for (int s = 0; s < 8; s++) ucode[op][s] = 16'h0000;
            ucode[op][0] = W_CO | W_MI;
            ucode[op][1] = W_RO | W_II | W_CE;
        end
        ucode[1][2]  = W_IO | W_MI;  ucode[1][3] = W_RO | W_AI;
        ucode[2][2]  = W_IO | W_MI;  ucode[2][3] = W_RO | W_BI;  ucode[2][4] = W_EO | W_AI | W_FI;
        ucode[3][2]  = W_IO | W_MI;  ucode[3][3] = W_RO | W_BI;  ucode[3][4] = W_EO | W_AI | W_FI | W_SU;
        ucode[4][2]  = W_IO | W_MI;  ucode[4][3] = W_AO | W_RI;
        ucode[5][2]  = W_IO | W_AI;
        ucode[6][2]  = W_IO | W_J;
        ucode[7][2]  = W_IO;
        ucode[8][2]  = W_IO;
        ucode[14][2] = W_AO | W_OI;
        ucode[15][2] = W_HLT;
    endtask

    function automatic logic [15:0] observed_word();
        return {bus.hlt, bus.mi, bus.ri, bus.ro, bus.ii, bus.io, bus.ai, bus.ao,
                bus.eo, bus.su, bus.bi, bus.oi, bus.ce, bus.co, bus.j, bus.fi};
    endfunction

    function automatic logic [15:0] expected_word(input logic r, input logic [3:0] op,
                                                  input logic c, input logic z);
        logic [15:0] w;
        if (r) return 16'h0000;
        if (m_halted) return W_HLT;
        if (m_step >= NUM_STEPS || m_step >= 8) return 16'h0000;
        w = ucode[op][m_step];
        if (m_step == 2 && op == 4'd7 && c) w = w | W_J;
        if (m_step == 2 && op == 4'd8 && z) w = w | W_J;
        return w;
    endfunction

    // Apply one cycle of inputs, check mid-cycle, then advance the model past the edge.
    task automatic cycle(input logic r, input logic [3:0] op, input logic c, input logic z);
        logic [15:0] obs;
        rst        = r;
        bus.opcode = op;
        bus.carry  = c;
        bus.zero   = z;
        @(negedge clk);
        obs = observed_word();
        check($sformatf("t_state r%0d op%0h", r, op), 32'(bus.t_state), 32'(m_step));
        check($sformatf("ctrl s%0d op%0h c%0d z%0d r%0d h%0d", m_step, op, c, z, r, m_halted),
              {16'h0000, obs}, {16'h0000, expected_word(r, op, c, z)});
        check("bus_excl", {31'd0, ($countones({bus.co, bus.ro, bus.io, bus.ao, bus.eo}) <= 1)},
              32'd1);
        @(posedge clk);
        #1;
        if (r) begin
            m_step   = 0;
            m_halted = 1'b0;
        end else if (m_halted) begin
            m_step = 2;
        end else if (m_step == 2 && op == 4'hF) begin
            m_halted = 1'b1;
        end else begin
            m_step = (m_step + 1) % NUM_STEPS;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
        for (int s = 0; s < NUM_STEPS; s++) cycle(1'b0, op, c, z);
    endtask

    initial begin
        logic [3:0] cur_op;
        build_ucode();
        rst        = 1'b1;
        bus.opcode = 4'h0;
        bus.carry  = 1'b0;
        bus.zero   = 1'b0;
        @(posedge clk);
        #1;
        m_step   = 0;
        m_halted = 1'b0;

        // Reset held two cycles, then the instruction walks from the test plan
        cycle(1'b1, 4'h0, 1'b0, 1'b0);
        cycle(1'b1, 4'h0, 1'b0, 1'b0);
        run_instr(4'h1, 1'b0, 1'b0);
        run_instr(4'h3, 1'b0, 1'b0);
        run_instr(4'h2, 1'b1, 1'b1);
        run_instr(4'h4, 1'b0, 1'b0);
        run_instr(4'h5, 1'b0, 1'b0);
        run_instr(4'h6, 1'b0, 1'b0);
        run_instr(4'h7, 1'b0, 1'b1);
        run_instr(4'h7, 1'b1, 1'b0);
        run_instr(4'h8, 1'b1, 1'b1);
        run_instr(4'h8, 1'b0, 1'b1);
        run_instr(4'hE, 1'b0, 1'b0);
        run_instr(4'h0, 1'b1, 1'b1);
        run_instr(4'hA, 1'b1, 1'b1);

        // HLT, ten halted cycles with wandering opcodes, then a reset pulse
        for (int s = 0; s < 3; s++) cycle(1'b0, 4'hF, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) cycle(1'b0, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        cycle(1'b1, 4'h2, 1'b0, 1'b0);
        run_instr(4'h1, 1'b0, 1'b0);

        // ADD aborted by reset in T3
        for (int s = 0; s < 3; s++) cycle(1'b0, 4'h2, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0);
        run_instr(4'h2, 1'b0, 1'b0);

        // Randomized instruction stream with occasional resets
        cur_op = 4'h0;
        for (int k = 0; k < 600; k++) begin
            if (m_halted) begin
                cur_op = 4'($urandom_range(0, 15));
            end else if (m_step == 0) begin
                cur_op = 4'($urandom_range(0, 15));
            end
            cycle(($urandom_range(0, 29) == 0), cur_op, 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sap_control_unit.md
Name: sap_control_unit

Overview:
Microcoded control sequencer for the 8-bit SAP-1 datapath: PC, MAR, RAM, IR, A/B registers, ALU, flag register and output register.
- Steps through a fixed-length T-state ring per instruction.
- Decodes the IR opcode nibble plus the registered carry/zero flags.
- Drives every bus-enable/load strobe, including the ALU's eo/su/fi controls.
- Sits beside the datapath; all control outputs are a combinational decode of registered state.

Parameters:
OP_WIDTH, 4, opcode width (IR upper nibble)
NUM_STEPS, 5, T-states per instruction; legal range 5..8
STEP_WIDTH, 3, width of t_state; must satisfy 2**STEP_WIDTH >= NUM_STEPS

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
opcode  input  OP_WIDTH  IR[7:4], valid from T2 onward
carry  input  1  registered carry flag
zero  input  1  registered zero flag
t_state  output  STEP_WIDTH  current microstep, 0..NUM_STEPS-1
hlt  output  1  clock-halt request / halted indicator
mi  output  1  MAR load
ri  output  1  RAM write
ro  output  1  RAM to bus
ii  output  1  IR load
io  output  1  IR operand (low nibble) to bus
ai  output  1  A load
ao  output  1  A to bus
eo  output  1  ALU result to bus (ALU enable)
su  output  1  ALU subtract select
bi  output  1  B load
oi  output  1  output register load
ce  output  1  PC increment
co  output  1  PC to bus
j  output  1  PC load (jump)
fi  output  1  flag register load

Behaviour:
- Registered state:
  - step counter, STEP_WIDTH bits.
  - mode FSM, two states: RUN and HALTED.
- Reset (rst high at a rising edge): step <= 0, mode <= RUN.
  - While rst is high, all control outputs are forced 0 combinationally; t_state reads the register.
  - Reset mid-instruction abandons it: no further strobes for that instruction.
- RUN:
  - step increments every cycle.
  - step == NUM_STEPS-1 wraps to 0.
  - No early exit; unused steps emit all-zero control words.
- Fetch, all opcodes:
  - T0: co, mi.
  - T1: ro, ii, ce.
- Execute, T2..T4, by opcode; unlisted steps are zero:
  - 0001 LDA: T2 io,mi; T3 ro,ai.
  - 0010 ADD: T2 io,mi; T3 ro,bi; T4 eo,ai,fi.
  - 0011 SUB: same as ADD, with su also asserted in T4 only.
  - 0100 STA: T2 io,mi; T3 ao,ri.
  - 0101 LDI: T2 io,ai.
  - 0110 JMP: T2 io,j.
  - 0111 JC: T2 io; j also asserted if carry==1.
  - 1000 JZ: T2 io; j also asserted if zero==1.
  - 1110 OUT: T2 ao,oi.
  - 1111 HLT: T2 hlt; mode <= HALTED at that edge.
  - 0000 and all other codes are NOP: execute steps all zero.
- Flags are sampled combinationally during T2. A preceding ADD/SUB's fi takes effect at the end of its T4, so it is visible to the next instruction.
- HALTED:
  - step is frozen at 2.
  - hlt = 1 continuously; all other control outputs are 0.
  - Only rst exits HALTED, returning to RUN at T0.
- Bus exclusivity: at most one of co, ro, io, ao, eo is asserted in any cycle. Verification checks this with an assertion.
- Latency: control word valid in the same cycle as t_state; no pipeline.
- For NUM_STEPS > 5, steps 5..NUM_STEPS-1 are all-zero padding.

Test Plan:
- Reset: rst=1 for 2 cycles → all outputs 0, t_state=0. After release: cycle 0 gives co=mi=1; cycle 1 gives ro=ii=ce=1; cycle 2 gives t_state=2.
- LDA (opcode=0001) → T2 io=mi=1; T3 ro=ai=1; T4 all strobes 0. Next cycle t_state=0 with co=mi=1 (wrap).
- SUB (opcode=0011) → T3 ro=bi=1; T4 eo=ai=fi=su=1. su=0 in every other step.
- JC with carry=0 → T2 io=1, j=0. Repeat with carry=1 → T2 io=j=1. JZ with zero=1/0 gives the analogous result.
- HLT (opcode=1111) → T2 hlt=1. For the next 10 cycles: t_state=2, hlt=1, all others 0, opcode changes ignored. Then rst pulse → t_state=0, co=mi=1, hlt=0.
- ADD with rst asserted during T3 → next cycle all outputs 0 and t_state=0. After release, fetch restarts; no eo/fi pulse occurs for the aborted ADD.
